// File: rtl/pipe_control.sv
// Pipelined control unit: decodes the ID-stage opcode and carries EX/MEM/WB
// control bits through three pipeline registers, plus a saturating illegal-opcode counter.
module pipe_control #(
  parameter bit          JUMP_EN = 1'b1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       Op_i,
  input  logic             valid_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic             Jump_o,
  output logic             RegDst_o,
  output logic             ALUSrc_o,
  output logic [1:0]       ALUOp_o,
  output logic             Branch_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             RegWrite_o,
  output logic             MemtoReg_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUOP_W = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic               regDst;
    logic               aluSrc;
    logic [ALUOP_W-1:0] aluOp;
    logic               branch;
    logic               memRead;
    logic               memWrite;
    logic               regWrite;
    logic               memtoReg;
  } ctrl_t;

  typedef struct packed {
    logic branch;
    logic memRead;
    logic memWrite;
    logic regWrite;
    logic memtoReg;
  } memCtrl_t;

  typedef struct packed {
    logic regWrite;
    logic memtoReg;
  } wbCtrl_t;

  ctrl_t             decCtrl;
  logic              decIllegal;
  logic              decJump;
  logic              accept;
  ctrl_t             idEx;
  memCtrl_t          exMem;
  wbCtrl_t           memWb;
  logic [CNT_W-1:0]  illegalCnt;

  // ID-stage decode; j carries no pipelined controls, only the combinational jump
  always_comb begin
    decCtrl    = '0;
    decIllegal = 1'b0;
    decJump    = 1'b0;
    case (Op_i)
      OP_RTYPE: begin
        decCtrl.regDst   = 1'b1;
        decCtrl.aluOp    = 2'b10;
        decCtrl.regWrite = 1'b1;
      end
      OP_ADDI: begin
        decCtrl.aluSrc   = 1'b1;
        decCtrl.aluOp    = 2'b11;
        decCtrl.regWrite = 1'b1;
      end
      OP_LW: begin
        decCtrl.aluSrc   = 1'b1;
        decCtrl.memRead  = 1'b1;
        decCtrl.memtoReg = 1'b1;
        decCtrl.regWrite = 1'b1;
      end
      OP_SW: begin
        decCtrl.aluSrc   = 1'b1;
        decCtrl.memWrite = 1'b1;
      end
      OP_BEQ: begin
        decCtrl.aluOp  = 2'b01;
        decCtrl.branch = 1'b1;
      end
      OP_J: begin
        if (JUMP_EN) decJump    = 1'b1;
        else         decIllegal = 1'b1;
      end
      default: decIllegal = 1'b1;
    endcase
  end

  assign Jump_o = valid_i & decJump;
  assign accept = valid_i & ~stall_i & ~flush_i;

  // Pipeline registers; flush squashes ID/EX and EX/MEM but never MEM/WB
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idEx  <= '0;
      exMem <= '0;
      memWb <= '0;
    end else begin
      idEx  <= accept ? decCtrl : '0;
      exMem <= flush_i ? '0 : '{branch:   idEx.branch,
                                memRead:  idEx.memRead,
                                memWrite: idEx.memWrite,
                                regWrite: idEx.regWrite,
                                memtoReg: idEx.memtoReg};
      memWb <= '{regWrite: exMem.regWrite, memtoReg: exMem.memtoReg};
    end
  end

  // Saturating count of illegal opcodes that actually leave ID
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      illegalCnt <= '0;
    end else if (accept && decIllegal && (illegalCnt != CNT_MAX)) begin
      illegalCnt <= illegalCnt + CNT_W'(1);
    end
  end

  assign RegDst_o      = idEx.regDst;
  assign ALUSrc_o      = idEx.aluSrc;
  assign ALUOp_o       = idEx.aluOp;
  assign Branch_o      = exMem.branch;
  assign MemRead_o     = exMem.memRead;
  assign MemWrite_o    = exMem.memWrite;
  assign RegWrite_o    = memWb.regWrite;
  assign MemtoReg_o    = memWb.memtoReg;
  assign illegal_cnt_o = illegalCnt;

endmodule

// File: tb/tb_pipe_control.sv
// Bench for pipe_control: two instances (jump enabled / 8-bit counter, jump disabled / 2-bit counter)
// driven from a vector table, with per-stage expectation queues.
module tb_pipe_control;

  localparam int unsigned CNT_W_A = 8;
  localparam int unsigned CNT_W_B = 2;
  localparam int unsigned NV      = 23;
  localparam int unsigned NP      = 10;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ADD = 6'b001000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_ILL = 6'b111111;

  // {regDst, aluSrc, aluOp[1:0], branch, memRead, memWrite, regWrite, memtoReg}
  localparam logic [8:0] C_R   = 9'b1_0_10_000_10;
  localparam logic [8:0] C_ADD = 9'b0_1_11_000_10;
  localparam logic [8:0] C_LW  = 9'b0_1_00_010_11;
  localparam logic [8:0] C_SW  = 9'b0_1_00_001_00;
  localparam logic [8:0] C_BEQ = 9'b0_0_01_100_00;
  localparam logic [8:0] C_Z   = 9'b0_0_00_000_00;

  typedef struct packed {
    logic [5:0] op;
    logic       valid;
    logic       stall;
    logic       flush;
    logic [8:0] ctrl;
    logic       illegal;
    logic       isJump;
  } vec_t;

  logic clk_i = 1'b0;
  logic rst_i;
  logic [5:0] Op_i;
  logic valid_i, stall_i, flush_i;

  logic jumpA, regDstA, aluSrcA, branchA, memReadA, memWriteA, regWriteA, memtoRegA;
  logic [1:0] aluOpA;
  logic [CNT_W_A-1:0] cntA;
  logic jumpB, regDstB, aluSrcB, branchB, memReadB, memWriteB, regWriteB, memtoRegB;
  logic [1:0] aluOpB;
  logic [CNT_W_B-1:0] cntB;

  pipe_control #(.JUMP_EN(1'b1), .CNT_W(CNT_W_A)) dutA (
    .clk_i(clk_i), .rst_i(rst_i), .Op_i(Op_i), .valid_i(valid_i),
    .stall_i(stall_i), .flush_i(flush_i), .Jump_o(jumpA),
    .RegDst_o(regDstA), .ALUSrc_o(aluSrcA), .ALUOp_o(aluOpA),
    .Branch_o(branchA), .MemRead_o(memReadA), .MemWrite_o(memWriteA),
    .RegWrite_o(regWriteA), .MemtoReg_o(memtoRegA), .illegal_cnt_o(cntA)
  );

  pipe_control #(.JUMP_EN(1'b0), .CNT_W(CNT_W_B)) dutB (
    .clk_i(clk_i), .rst_i(rst_i), .Op_i(Op_i), .valid_i(valid_i),
    .stall_i(stall_i), .flush_i(flush_i), .Jump_o(jumpB),
    .RegDst_o(regDstB), .ALUSrc_o(aluSrcB), .ALUOp_o(aluOpB),
    .Branch_o(branchB), .MemRead_o(memReadB), .MemWrite_o(memWriteB),
    .RegWrite_o(regWriteB), .MemtoReg_o(memtoRegB), .illegal_cnt_o(cntB)
  );

  always #5 clk_i = ~clk_i;

  int nChecks = 0;
  int nErrors = 0;
  int expCntA = 0;
  int expCntB = 0;
  logic [8:0] exQ[$];
  logic [8:0] memQ[$];
  logic [8:0] wbQ[$];
  vec_t vecs [NV];
  vec_t postVecs [NP];

  function automatic vec_t mk(input logic [5:0] op, input logic v, input logic s, input logic f,
                              input logic [8:0] c, input logic ill, input logic jmp);
    vec_t r;
    r.op = op; r.valid = v; r.stall = s; r.flush = f;
    r.ctrl = c; r.illegal = ill; r.isJump = jmp;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] allA();
    return {regDstA, aluSrcA, aluOpA, branchA, memReadA, memWriteA, regWriteA, memtoRegA};
  endfunction

  function automatic logic [8:0] allB();
    return {regDstB, aluSrcB, aluOpB, branchB, memReadB, memWriteB, regWriteB, memtoRegB};
  endfunction

  task automatic seedModel();
    exQ.delete(); memQ.delete(); wbQ.delete();
    exQ.push_back(C_Z); memQ.push_back(C_Z); wbQ.push_back(C_Z);
    expCntA = 0; expCntB = 0;
  endtask

  // One cycle: drive after the rising edge, compare at the falling edge, then queue expectations
  task automatic step(input string tag, input int idx, input vec_t v);
    logic [8:0] eEx, eMem, eWb;
    logic acc;
    @(posedge clk_i); #1;
    Op_i = v.op; valid_i = v.valid; stall_i = v.stall; flush_i = v.flush;
    @(negedge clk_i);
    if (exQ.size() == 0 || memQ.size() == 0 || wbQ.size() == 0) begin
      nChecks++; nErrors++;
      $display("FAIL %s[%0d] queue: got empty expected entry", tag, idx);
      return;
    end
    eEx = exQ.pop_front(); eMem = memQ.pop_front(); eWb = wbQ.pop_front();
    check($sformatf("%s[%0d] ex", tag, idx), 32'({regDstA, aluSrcA, aluOpA}), 32'(eEx[8:5]));
    check($sformatf("%s[%0d] mem", tag, idx), 32'({branchA, memReadA, memWriteA}), 32'(eMem[4:2]));
    check($sformatf("%s[%0d] wb", tag, idx), 32'({regWriteA, memtoRegA}), 32'(eWb[1:0]));
    check($sformatf("%s[%0d] pipeB", tag, idx), 32'(allB()), 32'({eEx[8:5], eMem[4:2], eWb[1:0]}));
    check($sformatf("%s[%0d] jumpA", tag, idx), 32'(jumpA), 32'(v.valid & v.isJump));
    check($sformatf("%s[%0d] jumpB", tag, idx), 32'(jumpB), 32'(0));
    check($sformatf("%s[%0d] cntA", tag, idx), 32'(cntA), 32'(expCntA));
    check($sformatf("%s[%0d] cntB", tag, idx), 32'(cntB), 32'(expCntB));
    acc = v.valid & ~v.stall & ~v.flush;
    exQ.push_back(acc ? v.ctrl : C_Z);
    memQ.push_back(v.flush ? C_Z : eEx);
    wbQ.push_back(eMem);
    if (acc && v.illegal && expCntA != 255) expCntA++;
    if (acc && (v.illegal || v.isJump) && expCntB != 3) expCntB++;
  endtask

  initial begin
    vecs[0]  = mk(OP_R,   1, 0, 0, C_R,   0, 0);
    vecs[1]  = mk(OP_LW,  1, 0, 0, C_LW,  0, 0);
    vecs[2]  = mk(OP_SW,  1, 0, 0, C_SW,  0, 0);
    vecs[3]  = mk(OP_BEQ, 1, 0, 0, C_BEQ, 0, 0);
    vecs[4]  = mk(OP_ADD, 1, 0, 0, C_ADD, 0, 0);
    vecs[5]  = mk(OP_J,   1, 0, 0, C_Z,   0, 1);
    vecs[6]  = mk(OP_ILL, 1, 0, 0, C_Z,   1, 0);
    vecs[7]  = mk(OP_LW,  1, 0, 0, C_LW,  0, 0);
    vecs[8]  = mk(OP_R,   1, 1, 0, C_R,   0, 0);
    vecs[9]  = mk(OP_R,   1, 0, 0, C_R,   0, 0);
    vecs[10] = mk(OP_LW,  1, 0, 0, C_LW,  0, 0);
    vecs[11] = mk(OP_SW,  1, 0, 1, C_SW,  0, 0);
    vecs[12] = mk(OP_ADD, 1, 0, 0, C_ADD, 0, 0);
    vecs[13] = mk(OP_ILL, 1, 1, 0, C_Z,   1, 0);
    vecs[14] = mk(OP_ILL, 1, 0, 1, C_Z,   1, 0);
    vecs[15] = mk(OP_ILL, 0, 0, 0, C_Z,   1, 0);
    vecs[16] = mk(OP_ILL, 1, 0, 0, C_Z,   1, 0);
    vecs[17] = mk(OP_ILL, 1, 0, 0, C_Z,   1, 0);
    vecs[18] = mk(OP_J,   0, 0, 0, C_Z,   0, 1);
    vecs[19] = mk(OP_BEQ, 1, 1, 1, C_BEQ, 0, 0);
    vecs[20] = mk(OP_R,   1, 0, 0, C_R,   0, 0);
    vecs[21] = mk(OP_LW,  1, 0, 0, C_LW,  0, 0);
    vecs[22] = mk(OP_SW,  1, 0, 0, C_SW,  0, 0);

    postVecs[0] = mk(OP_R,   1, 0, 0, C_R, 0, 0);
    for (int i = 1; i <= 5; i++) postVecs[i] = mk(OP_ILL, 1, 0, 0, C_Z, 1, 0);
    postVecs[6] = mk(OP_ILL, 1, 1, 0, C_Z, 1, 0);
    for (int i = 7; i < NP; i++) postVecs[i] = mk(OP_R, 0, 0, 0, C_Z, 0, 0);

    rst_i = 1'b0; Op_i = OP_R; valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    #3;
    check("reset regsA", 32'(allA()), 32'(0));
    check("reset regsB", 32'(allB()), 32'(0));
    check("reset cntA", 32'(cntA), 32'(0));
    #9 rst_i = 1'b1;
    seedModel();

    for (int i = 0; i < NV; i++) step("vec", i, vecs[i]);

    // Asynchronous reset in mid-cycle with every stage holding live controls
    @(posedge clk_i); #1;
    Op_i = OP_J; valid_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    #1;
    check("preRst loaded", 32'(allA() != 9'd0), 32'(1));
    rst_i = 1'b0;
    #1;
    check("midRst regsA", 32'(allA()), 32'(0));
    check("midRst regsB", 32'(allB()), 32'(0));
    check("midRst cntA", 32'(cntA), 32'(0));
    check("midRst cntB", 32'(cntB), 32'(0));
    check("midRst jumpA", 32'(jumpA), 32'(1));
    check("midRst jumpB", 32'(jumpB), 32'(0));
    valid_i = 1'b0;
    #1;
    check("midRst jumpA bubble", 32'(jumpA), 32'(0));
    @(posedge clk_i); #1;
    check("heldRst regsA", 32'(allA()), 32'(0));
    #1 rst_i = 1'b1;
    seedModel();

    for (int i = 0; i < NP; i++) step("post", i, postVecs[i]);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_control.md
PIPE_CONTROL -- requirements
Module: pipe_control

Interface
REQ-001 Parameter: JUMP_EN, default 1, enables decode of j (opcode 000010); 0 treats j as illegal.
REQ-002 Parameter: CNT_W, default 8, width of illegal-opcode counter.
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 rst_i  input  1  asynchronous, active-low reset.
REQ-005 Op_i  input  6  opcode of instruction currently in ID.
REQ-006 valid_i  input  1  ID holds a real instruction; 0 = bubble.
REQ-007 stall_i  input  1  load-use hazard; inject bubble into ID/EX.
REQ-008 flush_i  input  1  branch/jump taken; squash ID/EX and EX/MEM.
REQ-009 Jump_o  output  1  ID-stage combinational jump indication.
REQ-010 RegDst_o, ALUSrc_o  output  1 each  EX-stage controls.
REQ-011 ALUOp_o  output  2  EX-stage ALU operation class.
REQ-012 Branch_o, MemRead_o, MemWrite_o  output  1 each  MEM-stage controls.
REQ-013 RegWrite_o, MemtoReg_o  output  1 each  WB-stage controls.
REQ-014 illegal_cnt_o  output  CNT_W  count of accepted illegal opcodes.

Function
REQ-015 Decode (ID, combinational) SHALL be: 000000 R-type: RegDst=1, ALUSrc=0, ALUOp=10, RegWrite=1, all others 0.
REQ-016 001000 addi: ALUSrc=1, ALUOp=11, RegWrite=1, others 0.
REQ-017 100011 lw: ALUSrc=1, ALUOp=00, MemRead=1, MemtoReg=1, RegWrite=1, others 0.
REQ-018 101011 sw: ALUSrc=1, ALUOp=00, MemWrite=1, others 0.
REQ-019 000100 beq: ALUOp=01, Branch=1, others 0.
REQ-020 000010 j (JUMP_EN=1): Jump_o=1 combinationally when valid_i=1; all pipelined controls 0.
REQ-021 Any other opcode is illegal: all controls 0 (bubble).
REQ-022 Jump_o SHALL be 0 whenever valid_i=0.
REQ-023 Three pipeline registers: ID/EX (all controls), EX/MEM (MEM+WB controls), MEM/WB (WB controls).
REQ-024 Latency: EX outputs reflect Op_i of cycle N in N+1, MEM outputs in N+2, WB outputs in N+3.
REQ-025 ID/EX SHALL load all-zero when valid_i=0, stall_i=1, or flush_i=1; else the decoded word.
REQ-026 EX/MEM SHALL load all-zero when flush_i=1; else forward from ID/EX.
REQ-027 MEM/WB SHALL always forward from EX/MEM (flush never squashes WB).
REQ-028 flush_i and stall_i both high: flush behaviour applies (superset; ID/EX zero, EX/MEM zero).
REQ-029 Illegal-opcode acceptance: valid_i=1, stall_i=0, flush_i=0, opcode illegal per REQ-021.
REQ-030 illegal_cnt_o SHALL increment by 1 per acceptance, saturating at 2^CNT_W-1 (no wrap).
REQ-031 Stalled or flushed instructions SHALL NOT be counted; the re-issued instruction is counted once when accepted.

Reset
REQ-032 While rst_i=0, all pipeline registers and illegal_cnt_o SHALL be 0 immediately (asynchronously), independent of clk_i.
REQ-033 All registered outputs SHALL be 0 during reset; Jump_o remains combinational from Op_i/valid_i.
REQ-034 After rst_i deasserts, the first rising edge loads ID/EX per REQ-025; reset mid-stream discards all in-flight controls.

Verification
REQ-035 Back-to-back R, lw, sw, beq, addi with valid_i=1 -> EX/MEM/WB outputs match REQ-015..019 at +1/+2/+3 cycles.
REQ-036 lw then stall_i=1 for one cycle with Op_i=000000 held -> one all-zero EX cycle, R-type controls appear next cycle, illegal_cnt_o unchanged.
REQ-037 lw in EX, sw in ID, flush_i=1 -> next cycle EX and MEM controls all 0; the older WB-bound entry still reaches WB.
REQ-038 CNT_W=2, five accepted opcodes 111111 -> illegal_cnt_o 1,2,3,3,3; same opcode with stall_i=1 -> no increment.
REQ-039 JUMP_EN=0, Op_i=000010 valid -> Jump_o=0, counter +1; JUMP_EN=1 -> Jump_o=1, counter unchanged.
REQ-040 Assert rst_i=0 mid-clock with all stages loaded -> all registered outputs and illegal_cnt_o 0 before next edge.
